// File: rtl/ps2_morse_pkg.sv
// Shared PS/2 byte constants and parser state type for the keyboard-to-Morse path.
package ps2_morse_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BREAK     = 2'd1,
        EXT       = 2'd2,
        EXT_BREAK = 2'd3
    } parser_state_e;

    // Keyboard status/housekeeping bytes that never carry a key.
    function automatic logic is_housekeeping(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
               (b == PS2_ECHO) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Show-ahead key FIFO with a registered head byte so the output holds when empty.
module ps2_key_fifo #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [7:0]            data_i,
    input  logic                  pop_i,
    output logic [7:0]            data_o,
    output logic                  valid_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_c,
    output logic                  empty_c
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    head_q, head_d;
    logic          valid_q, valid_d;
    logic          push_fire, pop_fire;

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);
    assign data_o  = head_q;
    assign valid_o = valid_q;
    assign level_o = count_q;

    // Next pointers, occupancy and head byte; flush wins over push/pop.
    always_comb begin
        pop_fire  = pop_i && !empty_c;
        push_fire = push_i && (!full_c || pop_fire);
        wr_ptr_d  = wr_ptr_q + PW'(push_fire);
        rd_ptr_d  = rd_ptr_q + PW'(pop_fire);
        count_d   = count_q + CW'(push_fire) - CW'(pop_fire);
        head_d    = head_q;
        if (count_d != '0) begin
            if (push_fire && (wr_ptr_q == rd_ptr_d)) begin
                head_d = data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
        valid_d = (count_d != '0);
        if (flush_i) begin
            pop_fire  = 1'b0;
            push_fire = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            head_d    = 8'h00;
            valid_d   = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (rst_n && push_fire) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ps2_keycode_scheduler.sv
// Parses the PS/2 byte stream, filters repeats/housekeeping and queues make codes.
module ps2_keycode_scheduler
    import ps2_morse_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_LOG2 = 3,
    parameter bit          SUPPRESS_REPEAT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               ps2_received_data,
    input  logic                     ps2_received_data_strb,
    input  logic                     flush,
    output logic [7:0]               key_code,
    output logic                     key_valid,
    input  logic                     key_ready,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     overflow
);

    parser_state_e state_q, state_d;
    logic [7:0]    last_make_q, last_make_d;
    logic          overflow_q, overflow_d;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign overflow = overflow_q;
    assign pop      = key_ready && !fifo_empty;

    // Parser next state, push decision, held-key tracking and sticky overflow.
    always_comb begin
        state_d     = state_q;
        last_make_d = last_make_q;
        overflow_d  = overflow_q;
        push        = 1'b0;
        if (ps2_received_data_strb) begin
            unique case (state_q)
                IDLE: begin
                    if (ps2_received_data == PS2_BREAK) begin
                        state_d = BREAK;
                    end else if (ps2_received_data == PS2_EXT) begin
                        state_d = EXT;
                    end else if (is_housekeeping(ps2_received_data)) begin
                        state_d = IDLE;
                    end else if (SUPPRESS_REPEAT && (ps2_received_data == last_make_q)) begin
                        state_d = IDLE;
                    end else begin
                        push        = 1'b1;
                        last_make_d = ps2_received_data;
                    end
                end
                BREAK: begin
                    state_d = IDLE;
                    if (ps2_received_data == last_make_q) begin
                        last_make_d = 8'h00;
                    end
                end
                EXT: begin
                    state_d = (ps2_received_data == PS2_BREAK) ? EXT_BREAK : IDLE;
                end
                EXT_BREAK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        if (flush) begin
            state_d     = IDLE;
            last_make_d = 8'h00;
            overflow_d  = 1'b0;
            push        = 1'b0;
        end
    end

    // Parser, held-key and overflow registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_make_q <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_make_q <= last_make_d;
            overflow_q  <= overflow_d;
        end
    end

    ps2_key_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (ps2_received_data),
        .pop_i   (pop),
        .data_o  (key_code),
        .valid_o (key_valid),
        .level_o (fifo_level),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

endmodule

// File: tb/tb_ps2_keycode_scheduler.sv
// Scoreboard bench: expected key codes queued at stimulus, checked at each pop.
module tb_ps2_keycode_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       strb;
    logic       flush;
    logic       key_ready;
    logic       key_ready1;

    logic [7:0] key_code,  key_code1;
    logic       key_valid, key_valid1;
    logic [3:0] fifo_level, fifo_level1;
    logic       overflow,  overflow1;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    ps2_keycode_scheduler #(.FIFO_DEPTH_LOG2(3), .SUPPRESS_REPEAT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ps2_received_data(data), .ps2_received_data_strb(strb),
        .flush(flush), .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .fifo_level(fifo_level), .overflow(overflow));

    ps2_keycode_scheduler #(.FIFO_DEPTH_LOG2(3), .SUPPRESS_REPEAT(1'b0)) u_dut_norep (
        .clk(clk), .rst_n(rst_n), .ps2_received_data(data), .ps2_received_data_strb(strb),
        .flush(flush), .key_code(key_code1), .key_valid(key_valid1), .key_ready(key_ready1),
        .fifo_level(fifo_level1), .overflow(overflow1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && !flush && key_valid && key_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pop", 32'(key_code), 32'hFFFF_FFFF);
            end else begin
                chk("pop_order", 32'(key_code), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        data = b;
        strb = 1'b1;
        @(posedge clk); #1;
        strb = 1'b0;
    endtask

    task automatic send_exp(input logic [7:0] b);
        sb_q.push_back(b);
        send(b);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        key_ready = 1'b1;
        while (key_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        key_ready = 1'b0;
        if (n >= 20) chk("drain_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        logic [7:0] fill [8];
        fill = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};
        rst_n = 1'b0; data = 8'h00; strb = 1'b0; flush = 1'b0;
        key_ready = 1'b0; key_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_code", 32'(key_code), 32'h00);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // 1: single key, one-cycle latency, single pop
        send_exp(8'h1C);
        chk("t1_valid", 32'(key_valid), 32'd1);
        chk("t1_code", 32'(key_code), 32'h1C);
        chk("t1_level", 32'(fifo_level), 32'd1);
        key_ready = 1'b1;
        @(posedge clk); #1;
        key_ready = 1'b0;
        chk("t1_valid_after_pop", 32'(key_valid), 32'd0);
        chk("t1_level_after_pop", 32'(fifo_level), 32'd0);
        chk("t1_code_hold", 32'(key_code), 32'h1C);

        // 2: typematic suppression vs. no suppression
        do_flush();
        send_exp(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send_exp(8'h1C);
        chk("t2_level", 32'(fifo_level), 32'd2);
        chk("t2_norep_level", 32'(fifo_level1), 32'd4);
        chk("t2_norep_valid", 32'(key_valid1), 32'd1);
        chk("t2_norep_code", 32'(key_code1), 32'h1C);
        chk("t2_norep_ovf", 32'(overflow1), 32'd0);
        drain();

        // 3: extended and housekeeping bytes filtered
        do_flush();
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hAA); send(8'hFA);
        send_exp(8'h32);
        chk("t3_level", 32'(fifo_level), 32'd1);
        chk("t3_code", 32'(key_code), 32'h32);
        drain();

        // 4: overflow on ninth key, sticky until flush
        do_flush();
        for (int i = 0; i < 8; i++) send_exp(fill[i]);
        chk("t4_ovf_before", 32'(overflow), 32'd0);
        send(8'h44);
        chk("t4_level", 32'(fifo_level), 32'd8);
        chk("t4_ovf", 32'(overflow), 32'd1);
        drain();
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        chk("t4_empty", 32'(fifo_level), 32'd0);
        do_flush();
        chk("t4_ovf_flushed", 32'(overflow), 32'd0);

        // 5: push into full FIFO with simultaneous pop
        for (int i = 0; i < 8; i++) send_exp(fill[i]);
        key_ready = 1'b1;
        send_exp(8'h4B);
        key_ready = 1'b0;
        chk("t5_level", 32'(fifo_level), 32'd8);
        chk("t5_ovf", 32'(overflow), 32'd0);
        drain();

        // 6a: reset abandons a pending break prefix
        do_flush();
        send(8'hF0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_exp(8'h1C);
        chk("t6_rst_level", 32'(fifo_level), 32'd1);
        chk("t6_rst_code", 32'(key_code), 32'h1C);
        drain();

        // 6b: flush abandons the prefix and ignores a byte strobed with it
        send(8'hF0);
        data = 8'h2D; strb = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        strb = 1'b0; flush = 1'b0;
        chk("t6_flush_byte_dropped", 32'(fifo_level), 32'd0);
        send_exp(8'h1C);
        chk("t6_flush_level", 32'(fifo_level), 32'd1);
        chk("t6_flush_code", 32'(key_code), 32'h1C);
        drain();

        chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
